// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types and constants for the 8-bit ALU and its writeback stage.
//   alu_op_e     : ALU select codes
//   alu_flags_t  : architectural flag set, packed {c, v, z, n, gt, eq} (c = MSB)
//   occ_e        : occupancy of the 2-entry writeback buffer
//   C_OPS/V_OPS  : one-hot-per-opcode masks of the ops that define C and V
// -----------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [2:0] {
    ADD    = 3'b000,
    PASS   = 3'b001,
    MAX    = 3'b010,
    SHLADD = 3'b011,
    SHRADD = 3'b100,
    ABS    = 3'b101,
    ADD2B  = 3'b110,
    AND    = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic c;
    logic v;
    logic z;
    logic n;
    logic gt;
    logic eq;
  } alu_flags_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // Bit k of a mask is set when opcode k produces a meaningful flag.
  localparam logic [7:0] C_OPS = (8'b1 << ADD) | (8'b1 << PASS) | (8'b1 << ADD2B);
  localparam logic [7:0] V_OPS = (8'b1 << ADD) | (8'b1 << ADD2B);

  function automatic logic op_in_mask(input logic [7:0] mask, input logic [2:0] op);
    return mask[op];
  endfunction

endpackage

// File: rtl/alu_skid_buf2.sv
// -----------------------------------------------------------------------------
// alu_skid_buf2
// Generic 2-entry valid/ready skid buffer. Head register drives the output;
// the skid register absorbs one extra beat so in_ready can be registered and
// never depends combinationally on out_ready.
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : upstream handshake (in_ready registered)
//   in_data  [W]         : upstream payload
//   out_valid/out_ready  : downstream handshake (out_valid registered)
//   out_data [W]         : head payload, stable while stalled
// -----------------------------------------------------------------------------
module alu_skid_buf2
  import alu_pkg::*;
#(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  occ_e         occ_q;
  logic         in_ready_q;
  logic         out_valid_q;
  logic [W-1:0] head_q;
  logic [W-1:0] skid_q;

  logic push;
  logic pop;

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  // Occupancy FSM with its handshake outputs registered alongside the state,
  // so in_ready/out_valid are always (occ != TWO)/(occ != EMPTY).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the payload registers are reset too, because out_data must read
      // zero after reset; reset drops any buffered entry outright.
      occ_q       <= OCC_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      head_q      <= '0;
      skid_q      <= '0;
    end else begin
      // NOTE: all state here uses non-blocking assignment so every register
      // samples pre-edge values (head <= skid in TWO relies on this).
      case (occ_q)
        OCC_EMPTY: begin
          if (push) begin
            head_q      <= in_data;
            occ_q       <= OCC_ONE;
            out_valid_q <= 1'b1;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            head_q <= in_data;
          end else if (push) begin
            skid_q     <= in_data;
            occ_q      <= OCC_TWO;
            in_ready_q <= 1'b0;
          end else if (pop) begin
            occ_q       <= OCC_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        OCC_TWO: begin
          // push cannot happen here: in_ready_q is low in TWO.
          if (pop) begin
            head_q     <= skid_q;
            occ_q      <= OCC_ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          occ_q       <= OCC_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = head_q;

endmodule

// File: rtl/alu_wb_stage.sv
// -----------------------------------------------------------------------------
// alu_wb_stage
// Registered writeback stage behind the 8-bit combinational ALU. Buffers up to
// two {result, opcode, tag} entries in FIFO order and maintains the status
// register {C,V,Z,N,GT,EQ} plus a sticky overflow bit, both updated at accept.
//   clk, rst_n                 : clock, async active-low reset
//   in_valid/in_ready          : ALU-side handshake (in_ready registered)
//   in_w, in_op, in_dst        : result, ALU select code, destination tag
//   in_co..in_eq, in_fwe       : ALU flags and flag write enable
//   out_valid/out_ready        : consumer handshake
//   out_w, out_op, out_dst     : head entry fields
//   status [6]                 : {C,V,Z,N,GT,EQ}, bit 5 = C
//   sov, sov_clr               : sticky overflow and its clear
// -----------------------------------------------------------------------------
module alu_wb_stage
  import alu_pkg::*;
#(
  parameter int DW   = 8,
  parameter int TAGW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_w,
  input  logic            in_co,
  input  logic            in_ov,
  input  logic            in_zero,
  input  logic            in_neg,
  input  logic            in_gt,
  input  logic            in_eq,
  input  logic [2:0]      in_op,
  input  logic [TAGW-1:0] in_dst,
  input  logic            in_fwe,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_w,
  output logic [2:0]      out_op,
  output logic [TAGW-1:0] out_dst,
  output logic [5:0]      status,
  output logic            sov,
  input  logic            sov_clr
);

  localparam int PW = DW + 3 + TAGW;

  logic [PW-1:0] buf_in;
  logic [PW-1:0] buf_out;

  assign buf_in = {in_w, in_op, in_dst};

  alu_skid_buf2 #(
    .W (PW)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (buf_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (buf_out)
  );

  assign {out_w, out_op, out_dst} = buf_out;

  // Flags are architectural state: they follow accept order, not pop order,
  // so a stalled consumer never delays a status update.
  logic       accept;
  logic       flag_wr;
  alu_flags_t status_q, status_d;
  logic       sov_q, sov_d;

  assign accept  = in_valid & in_ready;
  assign flag_wr = accept & in_fwe;

  always_comb begin
    // NOTE: defaults first so every path assigns every output (no latches).
    status_d = status_q;
    sov_d    = sov_q;
    if (flag_wr) begin
      status_d.z  = in_zero;
      status_d.n  = in_neg;
      status_d.gt = in_gt;
      status_d.eq = in_eq;
      if (op_in_mask(C_OPS, in_op)) status_d.c = in_co;
      if (op_in_mask(V_OPS, in_op)) status_d.v = in_ov;
    end
    if (sov_clr) sov_d = 1'b0;
    // A new overflow in the clear cycle must not be lost: set wins.
    if (flag_wr && in_ov && op_in_mask(V_OPS, in_op)) sov_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= '0;
      sov_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      sov_q    <= sov_d;
    end
  end

  assign status = status_q;
  assign sov    = sov_q;

endmodule

// File: tb/tb_alu_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_wb_stage
// Directed self-checking bench for alu_wb_stage. Inputs change and outputs are
// sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_alu_wb_stage;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_w;
  logic       in_co, in_ov, in_zero, in_neg, in_gt, in_eq;
  logic [2:0] in_op;
  logic [2:0] in_dst;
  logic       in_fwe;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_w;
  logic [2:0] out_op;
  logic [2:0] out_dst;
  logic [5:0] status;
  logic       sov;
  logic       sov_clr;

  int n_total = 0;
  int n_pass  = 0;

  alu_wb_stage #(
    .DW   (8),
    .TAGW (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_w      (in_w),
    .in_co     (in_co),
    .in_ov     (in_ov),
    .in_zero   (in_zero),
    .in_neg    (in_neg),
    .in_gt     (in_gt),
    .in_eq     (in_eq),
    .in_op     (in_op),
    .in_dst    (in_dst),
    .in_fwe    (in_fwe),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_w     (out_w),
    .out_op    (out_op),
    .out_dst   (out_dst),
    .status    (status),
    .sov       (sov),
    .sov_clr   (sov_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (got running, expected done)");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op; flags given as {co, ov, zero, neg, gt, eq}.
  task automatic drive(input logic [7:0] w, input logic [2:0] op, input logic [2:0] dst,
                       input logic [5:0] fl, input logic fwe);
    in_valid = 1'b1;
    in_w     = w;
    in_op    = op;
    in_dst   = dst;
    {in_co, in_ov, in_zero, in_neg, in_gt, in_eq} = fl;
    in_fwe   = fwe;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_w      = '0;
    {in_co, in_ov, in_zero, in_neg, in_gt, in_eq} = '0;
    in_op     = '0;
    in_dst    = '0;
    in_fwe    = 1'b0;
    out_ready = 1'b0;
    sov_clr   = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_w",     out_w,     0);
    check("rst_status",    status,    0);
    check("rst_sov",       sov,       0);
    rst_n = 1'b1;
    tick();

    // Single op, one-cycle latency
    out_ready = 1'b1;
    drive(8'h3C, 3'b000, 3'd5, 6'b100010, 1'b1);
    tick();
    in_valid = 1'b0;
    check("single_valid",  out_valid, 1);
    check("single_w",      out_w,     8'h3C);
    check("single_op",     out_op,    3'b000);
    check("single_dst",    out_dst,   3'd5);
    check("single_status", status,    6'b100010);
    tick();
    check("single_popped", out_valid, 0);

    // Backpressure: two entries fill the buffer, a third is held off
    out_ready = 1'b0;
    drive(8'h11, 3'b001, 3'd1, 6'b000000, 1'b0);
    tick();
    check("bp_ready_one", in_ready, 1);
    check("bp_head_one",  out_w,    8'h11);
    drive(8'h22, 3'b010, 3'd2, 6'b000000, 1'b0);
    tick();
    check("bp_ready_two", in_ready,  0);
    check("bp_valid_two", out_valid, 1);
    check("bp_head_two",  out_w,     8'h11);
    drive(8'h33, 3'b011, 3'd3, 6'b000000, 1'b0);
    tick();
    check("bp_hold_w",     out_w,    8'h11);
    check("bp_hold_dst",   out_dst,  3'd1);
    check("bp_hold_ready", in_ready, 0);
    out_ready = 1'b1;
    tick();
    check("bp_second_w",  out_w,    8'h22);
    check("bp_second_op", out_op,   3'b010);
    check("bp_ready_back", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bp_third_w", out_w, 8'h33);
    tick();
    check("bp_drained", out_valid, 0);
    check("bp_status_kept", status, 6'b100010);

    // Selective flag update
    drive(8'h01, 3'b000, 3'd0, 6'b100000, 1'b1);
    tick();
    check("flag_add_c", status, 6'b100000);
    drive(8'h00, 3'b111, 3'd0, 6'b001000, 1'b1);
    tick();
    check("flag_and_hold_c", status, 6'b101000);
    drive(8'h05, 3'b010, 3'd0, 6'b000011, 1'b0);
    tick();
    check("flag_fwe0", status, 6'b101000);
    drive(8'h80, 3'b001, 3'd0, 6'b000100, 1'b1);
    tick();
    check("flag_pass_c", status, 6'b000100);

    // Sticky overflow
    drive(8'h7F, 3'b110, 3'd0, 6'b010000, 1'b1);
    tick();
    check("sov_set",   sov,    1);
    check("sov_set_v", status, 6'b010000);
    drive(8'h02, 3'b000, 3'd0, 6'b000001, 1'b1);
    tick();
    check("sov_sticky",   sov,    1);
    check("sov_v_clear",  status, 6'b000001);
    sov_clr = 1'b1;
    drive(8'h90, 3'b000, 3'd0, 6'b010000, 1'b1);
    tick();
    check("sov_set_wins", sov, 1);
    in_valid = 1'b0;
    tick();
    sov_clr = 1'b0;
    check("sov_cleared", sov, 0);
    drive(8'h44, 3'b001, 3'd0, 6'b010000, 1'b1);
    tick();
    in_valid = 1'b0;
    check("sov_pass_no_set", sov,    0);
    check("pass_v_held",     status, 6'b010000);
    tick();

    // Reset mid-operation with the buffer full
    out_ready = 1'b0;
    drive(8'hA1, 3'b110, 3'd6, 6'b010000, 1'b1);
    tick();
    drive(8'hA2, 3'b000, 3'd7, 6'b100000, 1'b1);
    tick();
    in_valid = 1'b0;
    check("mid_full",    in_ready, 0);
    check("mid_sov_pre", sov,      1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid",  out_valid, 0);
    check("mid_rst_ready",  in_ready,  1);
    check("mid_rst_status", status,    0);
    check("mid_rst_sov",    sov,       0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    check("mid_no_ghost1", out_valid, 0);
    tick();
    check("mid_no_ghost2", out_valid, 0);

    // Throughput: one result per cycle, in order, in_ready never drops
    for (int i = 0; i < 16; i++) begin
      drive(8'(i), 3'b011, 3'(i), 6'b000000, 1'b0);
      tick();
      check($sformatf("thru_w_%0d", i),     out_w,     32'(i));
      check($sformatf("thru_valid_%0d", i), out_valid, 1);
      check($sformatf("thru_ready_%0d", i), in_ready,  1);
    end
    in_valid = 1'b0;
    tick();
    check("thru_drained", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
